// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with memory handshakes, wait-state timeout and a sticky fault state.
module multicycle_control_unit #(
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        pc_sel,
    output logic        alua_src,
    output logic        alub_src,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_op,
    output logic [4:0]  br_op,
    output logic        ru_wr,
    output logic        dm_wr,
    output logic [2:0]  dm_ctrl,
    output logic [1:0]  ru_data_wr_src,
    output logic [2:0]  state,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(WAIT_TIMEOUT);
    localparam bit               TIMEOUT_EN = (WAIT_TIMEOUT != 0);

    state_t             state_q, state_d;
    logic [6:0]         opcode_q;
    logic [2:0]         funct3_q;
    logic               f7b5_q;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               fault_q;
    logic [1:0]         fault_code_q, fault_code_d;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_legal;
    logic unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_r     = (opcode_q == OP_R);
    assign is_i     = (opcode_q == OP_I);
    assign is_ld    = (opcode_q == OP_LD);
    assign is_st    = (opcode_q == OP_ST);
    assign is_br    = (opcode_q == OP_BR);
    assign is_jal   = (opcode_q == OP_JAL);
    assign is_jalr  = (opcode_q == OP_JALR);
    assign is_lui   = (opcode_q == OP_LUI);
    assign is_auipc = (opcode_q == OP_AUIPC);
    assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

    // Next state; a ready in the timeout cycle takes priority over the fault
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT)) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b10;
                end
            end
            S_DECODE: begin
                if (!is_legal) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b01;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_br)               state_d = S_FETCH;
                else if (is_ld || is_st) state_d = S_MEMORY;
                else                     state_d = S_WRITEBACK;
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    state_d = is_ld ? S_WRITEBACK : S_FETCH;
                end else if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT)) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b11;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_FAULT;
        endcase
    end

    // Wait counter restarts on every state entry and counts unanswered request cycles
    always_comb begin
        wait_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEMORY))) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            opcode_q     <= 7'd0;
            funct3_q     <= 3'd0;
            f7b5_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            fault_q      <= (state_d == S_FAULT);
            fault_code_q <= fault_code_d;
            if ((state_q == S_FETCH) && imem_ready) begin
                opcode_q <= instr[6:0];
                funct3_q <= instr[14:12];
                f7b5_q   <= instr[30];
            end
        end
    end

    // Handshake and write enables, gated by state so FAULT drives them all low
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        pc_sel   = 1'b0;
        ru_wr    = 1'b0;
        dm_wr    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_wr    = imem_ready;
            end
            S_EXECUTE: begin
                if (is_br) begin
                    pc_wr  = 1'b1;
                    pc_sel = br_taken;
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dm_wr    = is_st;
                pc_wr    = is_st && dmem_ready;
            end
            S_WRITEBACK: begin
                ru_wr  = 1'b1;
                pc_wr  = 1'b1;
                pc_sel = is_jal | is_jalr;
            end
            default: ;
        endcase
    end

    // Datapath steering decoded from the latched instruction fields
    always_comb begin
        alua_src       = is_auipc | is_br | is_jal;
        alub_src       = !is_r;
        imm_src        = 3'b000;
        alu_op         = 4'b0000;
        br_op          = 5'b00000;
        dm_ctrl        = 3'b011;
        ru_data_wr_src = 2'b00;
        if (is_st)              imm_src = 3'b001;
        if (is_lui || is_auipc) imm_src = 3'b010;
        if (is_br)              imm_src = 3'b100;
        if (is_jal)             imm_src = 3'b110;
        if (is_r)               alu_op  = {f7b5_q, funct3_q};
        if (is_i)               alu_op  = (funct3_q == 3'b101) ? {f7b5_q, funct3_q} : {1'b0, funct3_q};
        if (is_lui)             alu_op  = 4'b1011;
        if (is_br)              br_op   = {2'b01, funct3_q};
        if (is_jal || is_jalr)  br_op   = 5'b10000;
        if (is_ld || is_st)     dm_ctrl = funct3_q;
        if (is_ld)              ru_data_wr_src = 2'b01;
        if (is_jal || is_jalr)  ru_data_wr_src = 2'b10;
    end

    assign state      = state_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: a per-instruction cycle schedule
// built from the instruction class and memory wait counts is checked every cycle.
module tb_multicycle_control_unit;

    localparam int unsigned T = 15;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
    localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, br_taken;
    logic        imem_req, dmem_req, ir_wr, pc_wr, pc_sel, alua_src, alub_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_op;
    logic [4:0]  br_op;
    logic        ru_wr, dm_wr;
    logic [2:0]  dm_ctrl;
    logic [1:0]  ru_data_wr_src;
    logic [2:0]  state;
    logic        fault;
    logic [1:0]  fault_code;

    multicycle_control_unit #(.WAIT_TIMEOUT(T), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req),
        .dmem_req(dmem_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel),
        .alua_src(alua_src), .alub_src(alub_src), .imm_src(imm_src),
        .alu_op(alu_op), .br_op(br_op), .ru_wr(ru_wr), .dm_wr(dm_wr),
        .dm_ctrl(dm_ctrl), .ru_data_wr_src(ru_data_wr_src), .state(state),
        .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cls;
        logic       alua, alub;
        logic [2:0] imm;
        logic [3:0] aluop;
        logic [4:0] brop;
        logic [2:0] dmc;
        logic [1:0] rsrc;
    } dec_t;

    typedef struct {
        logic [2:0] st;
        logic       imem_req, dmem_req, ir_wr, pc_wr, pc_sel, ru_wr, dm_wr, fault;
        logic [1:0] fcode;
        logic       dec_v;
        dec_t       d;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncyc  = 0;

    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    // Instruction class and steering values straight from the decode table
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [2:0] f3 = ins[14:12];
        logic       f7 = ins[30];
        d.cls = C_ILL; d.alua = 1'b0; d.alub = 1'b1; d.imm = 3'b000;
        d.aluop = 4'b0000; d.brop = 5'b00000; d.dmc = 3'b011; d.rsrc = 2'b00;
        case (ins[6:0])
            7'b0110011: begin d.cls = C_R; d.alub = 1'b0; d.aluop = {f7, f3}; end
            7'b0010011: begin d.cls = C_I; d.aluop = (f3 == 3'b101) ? {f7, f3} : {1'b0, f3}; end
            7'b0000011: begin d.cls = C_LD; d.dmc = f3; d.rsrc = 2'b01; end
            7'b0100011: begin d.cls = C_ST; d.imm = 3'b001; d.dmc = f3; end
            7'b1100011: begin d.cls = C_BR; d.imm = 3'b100; d.alua = 1'b1; d.brop = {2'b01, f3}; end
            7'b1101111: begin d.cls = C_JAL; d.imm = 3'b110; d.alua = 1'b1; d.brop = 5'b10000; d.rsrc = 2'b10; end
            7'b1100111: begin d.cls = C_JALR; d.brop = 5'b10000; d.rsrc = 2'b10; end
            7'b0110111: begin d.cls = C_LUI; d.imm = 3'b010; d.aluop = 4'b1011; end
            7'b0010111: begin d.cls = C_AUIPC; d.imm = 3'b010; d.alua = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e.st = st; e.imem_req = 0; e.dmem_req = 0; e.ir_wr = 0; e.pc_wr = 0;
        e.pc_sel = 0; e.ru_wr = 0; e.dm_wr = 0; e.fault = 0; e.fcode = 2'b00;
        e.dec_v = 0; e.d = decode(32'h0);
        return e;
    endfunction

    function automatic exp_t mkd(input logic [2:0] st, input dec_t d);
        exp_t e = mk(st);
        e.dec_v = 1'b1;
        e.d = d;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be during it
    task automatic cyc(input logic ir, input logic [31:0] ins, input logic dr,
                       input logic bt, input exp_t e);
        imem_ready = ir; instr = ins; dmem_ready = dr; br_taken = bt;
        exp_q.push_back(e);
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_ready = 0; dmem_ready = 0; br_taken = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_imem_req", imem_req, 1);
        chk("rst_fault", fault, 0);
        chk("rst_fault_code", fault_code, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dm_wr", dm_wr, 0);
        chk("rst_pc_wr", pc_wr, 0);
        chk("rst_ru_wr", ru_wr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fault_seq(input logic [1:0] code);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = mk(3'd7);
            e.fault = 1'b1;
            e.fcode = code;
            cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), e);
        end
        do_reset();
    endtask

    // One instruction: wf/wm = wait cycles before imem/dmem ready, stop = abandon in MEMORY
    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm,
                             input logic bt, input bit stop, output int lat);
        dec_t d = decode(ins);
        exp_t e;
        int   w;
        int   start = ncyc;
        lat = -1;
        w = 0;
        forever begin
            e = mk(3'd0);
            e.imem_req = 1'b1;
            if (w == wf) begin
                e.ir_wr = 1'b1;
                cyc(1'b1, ins, 1'($urandom), 1'($urandom), e);
                break;
            end
            cyc(1'b0, $urandom, 1'($urandom), 1'($urandom), e);
            if (T != 0 && w == int'(T)) begin fault_seq(2'b10); return; end
            w++;
        end
        if (d.cls == C_ILL) begin
            cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), mk(3'd1));
            fault_seq(2'b01);
            return;
        end
        cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), mkd(3'd1, d));
        e = mkd(3'd2, d);
        if (d.cls == C_BR) begin
            e.pc_wr = 1'b1;
            e.pc_sel = bt;
            cyc(1'($urandom), $urandom, 1'($urandom), bt, e);
            lat = ncyc - start;
            return;
        end
        cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), e);
        if (d.cls == C_LD || d.cls == C_ST) begin
            w = 0;
            forever begin
                if (stop && w == wm) return;
                e = mkd(3'd3, d);
                e.dmem_req = 1'b1;
                e.dm_wr = (d.cls == C_ST);
                if (w == wm) begin
                    e.pc_wr = (d.cls == C_ST);
                    cyc(1'($urandom), $urandom, 1'b1, 1'($urandom), e);
                    break;
                end
                cyc(1'($urandom), $urandom, 1'b0, 1'($urandom), e);
                if (T != 0 && w == int'(T)) begin fault_seq(2'b11); return; end
                w++;
            end
            if (d.cls == C_ST) begin lat = ncyc - start; return; end
        end
        e = mkd(3'd4, d);
        e.ru_wr = 1'b1;
        e.pc_wr = 1'b1;
        e.pc_sel = (d.cls == C_JAL || d.cls == C_JALR);
        cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), e);
        lat = ncyc - start;
    endtask

    // Per-cycle comparison against the queued schedule
    always @(negedge clk) begin : compare
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", state, e.st);
            chk("imem_req", imem_req, e.imem_req);
            chk("dmem_req", dmem_req, e.dmem_req);
            chk("ir_wr", ir_wr, e.ir_wr);
            chk("pc_wr", pc_wr, e.pc_wr);
            chk("pc_sel", pc_sel, e.pc_sel);
            chk("ru_wr", ru_wr, e.ru_wr);
            chk("dm_wr", dm_wr, e.dm_wr);
            chk("fault", fault, e.fault);
            chk("fault_code", fault_code, e.fcode);
            if (e.dec_v) begin
                chk("alua_src", alua_src, e.d.alua);
                chk("alub_src", alub_src, e.d.alub);
                chk("imm_src", imm_src, e.d.imm);
                chk("alu_op", alu_op, e.d.aluop);
                chk("br_op", br_op, e.d.brop);
                chk("dm_ctrl", dm_ctrl, e.d.dmc);
                chk("ru_data_wr_src", ru_data_wr_src, e.d.rsrc);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int         lat;
        dec_t       d;
        logic [31:0] ins;
        int         r;
        rst_n = 1'b0; instr = '0; imem_ready = 0; dmem_ready = 0; br_taken = 0;
        @(posedge clk);
        #1;
        chk("init_state", state, 0);
        chk("init_imem_req", imem_req, 1);
        chk("init_fault", fault, 0);
        chk("init_ru_wr", ru_wr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        d = decode(32'h002081B3);
        chk("pin_add_aluop", d.aluop, 4'b0000);
        chk("pin_add_alub", d.alub, 0);
        d = decode(32'h0000A103);
        chk("pin_lw_dmctrl", d.dmc, 3'b010);
        chk("pin_lw_rsrc", d.rsrc, 2'b01);
        d = decode(32'h00208463);
        chk("pin_beq_brop", d.brop, 5'b01000);
        chk("pin_beq_imm", d.imm, 3'b100);
        chk("pin_beq_alua", d.alua, 1);

        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, lat);
        chk("lat_add", lat, 4);
        run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, lat);
        chk("lat_lw_wait3", lat, 8);
        run_instr(32'h0000A103, 0, 0, 1'b0, 1'b0, lat);
        chk("lat_lw", lat, 5);
        run_instr(32'h0020A023, 0, 0, 1'b0, 1'b0, lat);
        chk("lat_sw", lat, 4);
        run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, lat);
        chk("lat_beq", lat, 3);
        run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, lat);
        chk("lat_jal", lat, 4);
        run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0, lat);
        chk("lat_jalr", lat, 4);
        run_instr(32'h123450B7, 0, 0, 1'b0, 1'b0, lat);
        chk("lat_lui", lat, 4);
        run_instr(32'h002081B3, 15, 0, 1'b0, 1'b0, lat);
        chk("lat_fetch_ready_at_limit", lat, 19);
        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, lat);
        run_instr(32'h002081B3, 16, 0, 1'b0, 1'b0, lat);
        run_instr(32'h0020A023, 0, 16, 1'b0, 1'b0, lat);

        run_instr(32'h0020A023, 0, 2, 1'b0, 1'b1, lat);
        chk("pre_rst_dm_wr", dm_wr, 1);
        chk("pre_rst_dmem_req", dmem_req, 1);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            if ($urandom_range(15) == 0) begin
                do ins[6:0] = 7'($urandom); while (decode(ins).cls != C_ILL);
            end else begin
                ins[6:0] = ops[$urandom_range(8)];
            end
            r = $urandom_range(19);
            lat = (r == 0) ? 15 + $urandom_range(1) : $urandom_range(2);
            r = $urandom_range(19);
            run_instr(ins, lat, (r == 0) ? 15 + $urandom_range(1) : $urandom_range(2),
                      1'($urandom), 1'b0, lat);
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
